// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared funct3 encodings and MEM-stage FSM state type
//
// Purpose : constants and types shared by the MEM stage and its lane aligner.
// Contents: F3_* load/store funct3 encodings, mem_state_t FSM state enum.

package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - combinational byte-lane alignment and load extension
//
// Purpose : fault detection, byte enables and lane-replicated store data for the
//           current request, plus lane selection and sign/zero extension of
//           returned read data for the access in flight.
// Ports   : mem_read_i/mem_write_i/funct3_i/addr_lo_i/store_data_i - current request
//           fault_o, byteenable_o, writedata_o                       - request decode
//           ld_funct3_i/ld_addr_lo_i/rdata_i                         - in-flight load
//           load_data_o                                              - extended load data

module mem_lsu_align
  import riscv_mem_pkg::*;
(
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  output logic        fault_o,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic        legal;
  logic        misal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Unsigned variants exist only for loads, so they are illegal on a store.
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (funct3_i)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1;       misal = addr_lo_i[0]; end
      F3_W:  begin legal = 1'b1;       misal = |addr_lo_i;   end
      F3_BU: legal = mem_read_i;
      F3_HU: begin legal = mem_read_i; misal = addr_lo_i[0]; end
      default: legal = 1'b0;
    endcase
    fault_o = (mem_read_i | mem_write_i) & (~legal | misal);
  end

  // funct3[1:0] encodes the width for both signed and unsigned forms.
  always_comb begin
    byteenable_o = 4'b0000;
    case (funct3_i[1:0])
      2'b00:   byteenable_o = 4'b0001 << addr_lo_i;
      2'b01:   byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      2'b10:   byteenable_o = 4'b1111;
      default: byteenable_o = 4'b0000;
    endcase
  end

  // Replicating store data across lanes lets the slave pick it up from
  // whichever lane the byte enables select, with no shifter.
  always_comb begin
    writedata_o = 32'h0;
    case (funct3_i[1:0])
      2'b00:   writedata_o = {4{store_data_i[7:0]}};
      2'b01:   writedata_o = {2{store_data_i[15:0]}};
      2'b10:   writedata_o = store_data_i;
      default: writedata_o = 32'h0;
    endcase
  end

  always_comb begin
    lane_b = rdata_i[7:0];
    case (ld_addr_lo_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase
    lane_h = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_data_o = 32'h0;
    case (ld_funct3_i)
      F3_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data_o = {24'h0, lane_b};
      F3_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data_o = {16'h0, lane_h};
      F3_W:    load_data_o = rdata_i;
      default: load_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_avalon.sv
// rtl/mem_stage_avalon.sv - RISC-V MEM stage with Avalon-MM master interface
//
// Purpose : issues loads/stores as Avalon-MM transactions, extends load data and
//           passes ALU result, rd and writeback controls through to MEM/WB. stall
//           holds the upstream pipeline and the MEM/WB enable while a bus access
//           is outstanding.
// Ports   : CLK, RST_n (async, active-low)
//           Address, StoreData, funct3, MemRead, MemWrite, MemtoReg, RegWrite,
//           instr5b                                          - from EX/MEM
//           oData, oAddress, oinstr5b, oMemtoReg, oRegWrite  - to MEM/WB
//           stall, oFault                                    - pipeline control
//           avm_*                                            - Avalon-MM master

module mem_stage_avalon
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [31:0]       Address,
  input  logic [31:0]       StoreData,
  input  logic [2:0]        funct3,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [4:0]        instr5b,
  output logic [31:0]       oData,
  output logic [31:0]       oAddress,
  output logic [4:0]        oinstr5b,
  output logic              oMemtoReg,
  output logic              oRegWrite,
  output logic              stall,
  output logic              oFault,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  mem_state_t        state_q, state_d;
  logic              avm_read_q, avm_read_d;
  logic              avm_write_q, avm_write_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic [3:0]        avm_be_q, avm_be_d;
  logic [31:0]       avm_wdata_q, avm_wdata_d;
  logic [31:0]       odata_q, odata_d;
  // Load shape is latched at issue so extension does not depend on the
  // upstream inputs staying put while the read is outstanding.
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_addr_lo_q, ld_addr_lo_d;

  logic              fault;
  logic              acc;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       ld_ext;

  mem_lsu_align u_align (
    .mem_read_i   (MemRead),
    .mem_write_i  (MemWrite),
    .funct3_i     (funct3),
    .addr_lo_i    (Address[1:0]),
    .store_data_i (StoreData),
    .fault_o      (fault),
    .byteenable_o (be_c),
    .writedata_o  (wdata_c),
    .ld_funct3_i  (ld_funct3_q),
    .ld_addr_lo_i (ld_addr_lo_q),
    .rdata_i      (avm_readdata),
    .load_data_o  (ld_ext)
  );

  assign acc = (MemRead | MemWrite) & ~fault;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_write_q   <= 1'b0;
      avm_address_q <= '0;
      avm_be_q      <= 4'b0000;
      avm_wdata_q   <= 32'h0;
      odata_q       <= 32'h0;
      ld_funct3_q   <= 3'b000;
      ld_addr_lo_q  <= 2'b00;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_write_q   <= avm_write_d;
      avm_address_q <= avm_address_d;
      avm_be_q      <= avm_be_d;
      avm_wdata_q   <= avm_wdata_d;
      odata_q       <= odata_d;
      ld_funct3_q   <= ld_funct3_d;
      ld_addr_lo_q  <= ld_addr_lo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_write_d   = avm_write_q;
    avm_address_d = avm_address_q;
    avm_be_d      = avm_be_q;
    avm_wdata_d   = avm_wdata_q;
    odata_d       = odata_q;
    ld_funct3_d   = ld_funct3_q;
    ld_addr_lo_d  = ld_addr_lo_q;

    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d       = REQ;
          avm_read_d    = MemRead;
          avm_write_d   = MemWrite;
          avm_address_d = ADDR_W'({Address[31:2], 2'b00});
          avm_be_d      = be_c;
          avm_wdata_d   = wdata_c;
          ld_funct3_d   = funct3;
          ld_addr_lo_d  = Address[1:0];
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (avm_write_q) begin
            state_d = DONE;
          end else if (avm_readdatavalid) begin
            odata_d = ld_ext;
            state_d = DONE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid) begin
          odata_d = ld_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall = ((state_q == IDLE) & acc) | (state_q == REQ) | (state_q == WAIT_RD);

  assign oFault         = fault;
  assign oRegWrite      = RegWrite & ~fault;
  assign oAddress       = Address;
  assign oinstr5b       = instr5b;
  assign oMemtoReg      = MemtoReg;
  assign oData          = odata_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_byteenable = avm_be_q;
  assign avm_writedata  = avm_wdata_q;

endmodule

// File: tb/tb_mem_stage_avalon.sv
// tb/tb_mem_stage_avalon.sv - self-checking bench for mem_stage_avalon

module tb_mem_stage_avalon;

  logic        CLK;
  logic        RST_n;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic [2:0]  funct3;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic [4:0]  instr5b;
  logic [31:0] oData;
  logic [31:0] oAddress;
  logic [4:0]  oinstr5b;
  logic        oMemtoReg;
  logic        oRegWrite;
  logic        stall;
  logic        oFault;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  mem_stage_avalon #(.ADDR_W(32)) dut (
    .CLK               (CLK),
    .RST_n             (RST_n),
    .Address           (Address),
    .StoreData         (StoreData),
    .funct3            (funct3),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemtoReg          (MemtoReg),
    .RegWrite          (RegWrite),
    .instr5b           (instr5b),
    .oData             (oData),
    .oAddress          (oAddress),
    .oinstr5b          (oinstr5b),
    .oMemtoReg         (oMemtoReg),
    .oRegWrite         (oRegWrite),
    .stall             (stall),
    .oFault            (oFault),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_byteenable    (avm_byteenable),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          wt;
    int          lat;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] od;
    int          stl;
    logic        flt;
  } vec_t;

  localparam int NVEC = 14;
  vec_t        vecs[NVEC];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_od = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_nop();
    MemRead           = 1'b0;
    MemWrite          = 1'b0;
    MemtoReg          = 1'b0;
    RegWrite          = 1'b0;
    funct3            = 3'b000;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          stl;
    int          cmd;
    int          lat_cnt;
    bit          done;
    bit          unstable;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    string       tag;
    v         = vecs[i];
    tag       = $sformatf("v%0d", i);
    Address   = v.addr;
    StoreData = v.sdata;
    funct3    = v.f3;
    MemRead   = v.rd;
    MemWrite  = v.wr;
    MemtoReg  = v.rd;
    RegWrite  = 1'b1;
    instr5b   = 5'(i + 1);
    avm_readdata      = v.rdata;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    stl = 0; cmd = 0; lat_cnt = -1; done = 0; unstable = 0;
    cap_addr = 32'h0; cap_be = 4'h0; cap_wd = 32'h0;
    #1;
    check({tag, " fault"}, {31'h0, oFault}, {31'h0, v.flt});
    check({tag, " regwrite"}, {31'h0, oRegWrite}, {31'h0, ~v.flt});
    check({tag, " passthru"}, {oAddress[26:0], oinstr5b}, {v.addr[26:0], 5'(i + 1)});
    for (int c = 0; c < 40 && !done; c++) begin
      if (avm_read || avm_write) begin
        if (cmd == 0) begin
          cap_addr = avm_address; cap_be = avm_byteenable; cap_wd = avm_writedata;
        end else if (cap_addr !== avm_address || cap_be !== avm_byteenable ||
                     cap_wd !== avm_writedata) begin
          unstable = 1;
        end
        cmd++;
        avm_waitrequest = (cmd <= v.wt);
        if (!avm_waitrequest && avm_read) lat_cnt = 0;
      end else begin
        avm_waitrequest = 1'b0;
        if (lat_cnt >= 0) lat_cnt++;
      end
      avm_readdatavalid = (lat_cnt == v.lat);
      if (stall) stl++;
      else done = 1;
      if (!done) step();
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout stall never dropped", tag);
    end
    check({tag, " stall_cycles"}, stl, v.stl);
    check({tag, " cmd_cycles"}, cmd, v.flt ? 0 : 1 + v.wt);
    if (!v.flt) begin
      check({tag, " address"}, cap_addr, {v.addr[31:2], 2'b00});
      check({tag, " byteenable"}, {28'h0, cap_be}, {28'h0, v.be});
      check({tag, " cmd_stable"}, {31'h0, unstable}, 32'h0);
      if (v.wr) check({tag, " writedata"}, cap_wd, v.wd);
      if (v.rd) begin
        check({tag, " oData"}, oData, v.od);
        last_od = v.od;
      end
    end
    set_nop();
    step();
    check({tag, " idle_stall"}, {31'h0, stall}, 32'h0);
  endtask

  initial begin
    //            rd    wr    f3      addr        sdata         rdata         wt lat be     wd            od            stl flt
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 32'hDEADBEEF, 32'h0,        2, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h12345678, 32'h0,        2, 0, 4'h8, 32'h78787878, 32'h0,        4, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF7F01, 0, 1, 4'h8, 32'h0,        32'hFFFFFF80, 3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF7F01, 0, 2, 4'h8, 32'h0,        32'h00000080, 4, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80FF7F01, 1, 1, 4'hC, 32'h0,        32'hFFFF80FF, 4, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h200, 32'h0,        32'h80FF7F01, 0, 0, 4'h3, 32'h0,        32'h00007F01, 2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h80FF7F01, 0, 1, 4'h0, 32'h0,        32'h0,        0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h80FF7F01, 0, 5, 4'hF, 32'h0,        32'h80FF7F01, 7, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h304, 32'h0,        32'hCAFEF00D, 1, 0, 4'hF, 32'h0,        32'hCAFEF00D, 3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h106, 32'hAAAA5555, 32'h0,        0, 0, 4'hC, 32'h55555555, 32'h0,        2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h11223344, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h201, 32'h0,        32'h80FF7F01, 0, 1, 4'h2, 32'h0,        32'h0000007F, 3, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b110, 32'h200, 32'h0,        32'h80FF7F01, 0, 1, 4'h0, 32'h0,        32'h0,        0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 1'b1};

    RST_n        = 1'b0;
    Address      = 32'h0;
    StoreData    = 32'h0;
    instr5b      = 5'h0;
    avm_readdata = 32'h0;
    set_nop();
    #1;
    check("reset avm_cmd", {30'h0, avm_read, avm_write}, 32'h0);
    check("reset avm_address", avm_address, 32'h0);
    check("reset avm_be_wd", {avm_byteenable, avm_writedata[27:0]}, 32'h0);
    check("reset oData", oData, 32'h0);
    check("reset stall", {31'h0, stall}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Non-memory instruction: zero latency, oData held, stray readdatavalid ignored.
    Address = 32'h55; funct3 = 3'b111; RegWrite = 1'b1; MemtoReg = 1'b0; instr5b = 5'd9;
    avm_readdata = 32'h12345678; avm_readdatavalid = 1'b1;
    #1;
    check("nop stall", {31'h0, stall}, 32'h0);
    check("nop fault", {31'h0, oFault}, 32'h0);
    check("nop regwrite", {31'h0, oRegWrite}, 32'h1);
    check("nop oAddress", oAddress, 32'h55);
    step();
    check("nop oData held", oData, last_od);
    check("nop no cmd", {30'h0, avm_read, avm_write}, 32'h0);
    set_nop();

    // Back-to-back: next store presented in the DONE cycle of the previous one.
    Address = 32'h100; StoreData = 32'h01020304; funct3 = 3'b010; MemWrite = 1'b1; RegWrite = 1'b0;
    begin
      bit b2b_done = 0;
      for (int c = 0; c < 10 && !b2b_done; c++) begin
        step();
        if (!stall) b2b_done = 1;
      end
      if (!b2b_done) begin
        errors++;
        $display("FAIL b2b timeout waiting for DONE");
      end
    end
    Address = 32'h101; StoreData = 32'h0000005A; funct3 = 3'b000;
    step();
    check("b2b idle stall", {31'h0, stall}, 32'h1);
    check("b2b idle no cmd", {31'h0, avm_write}, 32'h0);
    step();
    check("b2b write", {31'h0, avm_write}, 32'h1);
    check("b2b be", {28'h0, avm_byteenable}, 32'h2);
    check("b2b wdata", avm_writedata, 32'h5A5A5A5A);
    set_nop();
    step();
    step();

    // Reset during WAIT_RD.
    Address = 32'h400; funct3 = 3'b010; MemRead = 1'b1; avm_readdata = 32'hFFFFFFFF;
    step();
    check("rst pre REQ read", {31'h0, avm_read}, 32'h1);
    step();
    check("rst pre WAIT stall", {31'h0, stall}, 32'h1);
    check("rst pre WAIT read", {31'h0, avm_read}, 32'h0);
    MemRead = 1'b0;
    RST_n   = 1'b0;
    #1;
    check("rst avm_cmd", {30'h0, avm_read, avm_write}, 32'h0);
    check("rst avm_address", avm_address, 32'h0);
    check("rst avm_be_wd", {avm_byteenable, avm_writedata[27:0]}, 32'h0);
    check("rst oData", oData, 32'h0);
    check("rst stall", {31'h0, stall}, 32'h0);
    @(negedge CLK);
    RST_n = 1'b1;
    avm_readdatavalid = 1'b1;
    step();
    check("post rst stall", {31'h0, stall}, 32'h0);
    check("post rst oData", oData, 32'h0);
    set_nop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage_avalon.md
# mem_stage_avalon

Memory-access (MEM) stage of the five-stage RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store requests into Avalon-MM master transactions with byte lanes, sign- or zero-extends load data, and passes ALU result, rd and writeback controls through to MEM/WB. While a bus access is outstanding it asserts `stall`, which freezes the upstream pipeline and holds the MEM/WB enable low.

## Interface
- `ADDR_W`, 32: Avalon byte-address width.
- `CLK`  in  1  clock, rising edge.
- `RST_n`  in  1  reset, asynchronous, active-low.
- `Address`  in  32  ALU result: effective address, or passthrough value.
- `StoreData`  in  32  rs2 value.
- `funct3`  in  3  load/store width and signedness.
- `MemRead`, `MemWrite`  in  1  access request (never both).
- `MemtoReg`, `RegWrite`  in  1  writeback controls.
- `instr5b`  in  5  rd.
- `oData`  out  32  extended load data; valid in the DONE cycle.
- `oAddress`  out  32  `Address`, passed through combinationally.
- `oinstr5b`, `oMemtoReg`  out  5/1  passed through combinationally.
- `oRegWrite`  out  1  `RegWrite & ~oFault`.
- `stall`  out  1  hold upstream stages and the MEM/WB enable.
- `oFault`  out  1  misaligned access or illegal funct3; combinational.
- `avm_address`  out  ADDR_W  word-aligned: `{Address[31:2],2'b00}`.
- `avm_read`, `avm_write`  out  1  Avalon commands.
- `avm_byteenable`  out  4  byte lanes.
- `avm_writedata`  out  32  lane-replicated store data.
- `avm_readdata`  in  32  read data.
- `avm_waitrequest`, `avm_readdatavalid`  in  1  slave handshake.

## Operation
- Access request: `acc = (MemRead|MemWrite) & ~oFault`.
- `oFault` conditions:
  - Halfword with `Address[0]=1`.
  - Word with `Address[1:0]≠0`.
  - funct3 ∉ {000,001,010,100,101} for loads.
  - funct3 ∉ {000,001,010} for stores.
  - A faulting access issues no bus cycle and does not stall.
- Byte enables:
  - Byte: `4'b0001<<Address[1:0]`.
  - Half: `Address[1]?1100:0011`.
  - Word: `1111`.
- Write data:
  - SB: `{4{rs2[7:0]}}`.
  - SH: `{2{rs2[15:0]}}`.
  - SW: `rs2`.
- Load extraction: select the lane by `Address[1:0]`.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
- FSM states: IDLE, REQ, WAIT_RD, DONE.
  - IDLE → REQ when `acc`. On that edge, register `avm_read`/`avm_write`, address, byteenable and writedata.
  - REQ: hold all `avm_*` stable while `avm_waitrequest=1`.
    - On acceptance (`waitrequest=0`), deassert the command.
    - Write accepted → DONE.
    - Read accepted with `readdatavalid=1` in the same cycle → capture data, go to DONE.
    - Read accepted otherwise → WAIT_RD.
  - WAIT_RD: on `readdatavalid=1`, capture extended `avm_readdata` into `oData`, go to DONE. Otherwise stay.
  - DONE → IDLE unconditionally. The pipeline advances on this edge.
- `stall = (state==IDLE & acc) | state==REQ | state==WAIT_RD`.
- Non-memory instructions pass through with `stall=0` and zero latency. `oData` keeps its last value.
- There is no flush input: once issued, an access always completes.
- `readdatavalid` outside REQ/WAIT_RD is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `avm_read`, `avm_write`, `avm_address`, `avm_byteenable`, `avm_writedata`, `oData` = 0.
  - `stall` follows its equation (0 when idle with no request).
- Reset asserted mid-transaction aborts immediately to IDLE and drops the command. The slave is reset together with the core.
- Zero-wait store: 3 cycles (IDLE, REQ, DONE). `stall` is high for 2 cycles.
- Zero-wait load with 1-cycle read latency: 4 cycles (IDLE, REQ, WAIT_RD, DONE). `stall` is high for 3 cycles.
- Each `waitrequest` cycle or extra read-latency cycle adds exactly one stall cycle.
- Back-to-back accesses: the next access is detected in the IDLE cycle immediately after DONE.

## Structure
- Package `riscv_mem_pkg`:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `mem_state_t` enum.
- Sub-module `mem_lsu_align`: purely combinational. It produces fault, byteenable and writedata, and performs load extraction/extension. The FSM and Avalon registers stay in the top.

## Test plan
- SW rs2=0xDEADBEEF to 0x100, `waitrequest=0`:
  - Required: `avm_write=1` for one cycle, `address=0x100`, `be=1111`, `stall` high 2 cycles.
- SB 0x12345678 to 0x103, `waitrequest` high 2 cycles:
  - Required: `be=1000`, `writedata=0x78787878` held stable for 3 cycles, `stall` high 4 cycles.
- Reads of `readdata=0x80FF7F01`:
  - LB at 0x203 → `oData=0xFFFFFF80`.
  - LBU at 0x203 → `0x00000080`.
  - LH at 0x202 → `0xFFFF80FF`.
  - LHU at 0x200 → `0x00007F01`.
- LW at 0x102 with MemRead=1:
  - Required: `oFault=1`, `oRegWrite=0`, no `avm_read`, `stall=0`.
- LW with `readdatavalid` delayed 5 cycles after acceptance:
  - Required: `stall` high through WAIT_RD; `oData` correct in DONE.
- `RST_n` pulsed low during WAIT_RD:
  - Required: all `avm_*`=0, state IDLE, `stall=0` when no request is present.
